// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad front end.
// Key code = row*4 + col; codes 0-9 are digits, 10/11/12 are START/OK/RESET,
// and 13-15 are unused and decode as ERROR.
package keypad_pkg;

  localparam int unsigned ROWS        = 4;
  localparam int unsigned COLS        = 4;
  localparam int unsigned SLOT_CYCLES = 3;
  localparam int unsigned CODE_W      = 4;
  localparam int unsigned CNT_W       = 3;

  localparam logic [CODE_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [CODE_W-1:0] KEY_START = 4'd10;
  localparam logic [CODE_W-1:0] KEY_OK    = 4'd11;
  localparam logic [CODE_W-1:0] KEY_RESET = 4'd12;
  localparam logic [CODE_W-1:0] ERROR_NUM = 4'b1111;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_ERROR = 2'd2
  } res_kind_e;

  // One full-scan result: what was seen plus the key code when kind is KEY.
  typedef struct packed {
    res_kind_e         kind;
    logic [CODE_W-1:0] code;
  } scan_res_t;

  localparam scan_res_t SCAN_NONE = '{kind: RES_NONE, code: 4'd0};

  // Signals handed to the charger control FSM.
  typedef struct packed {
    logic              idle;
    logic [CODE_W-1:0] data;
    logic              start;
    logic              ok;
    logic              reset;
  } key_out_t;

  localparam key_out_t OUT_IDLE = '{idle: 1'b1, data: ERROR_NUM,
                                    start: 1'b0, ok: 1'b0, reset: 1'b0};

  // Map a committed result onto the output pattern.
  function automatic key_out_t decode_result(input scan_res_t r);
    key_out_t o;
    o = OUT_IDLE;
    if (r.kind != RES_NONE) begin
      o.idle = 1'b0;
      if (r.kind == RES_KEY) begin
        if (r.code <= DIGIT_MAX) begin
          o.data = r.code;
        end else begin
          o.start = (r.code == KEY_START);
          o.ok    = (r.code == KEY_OK);
          o.reset = (r.code == KEY_RESET);
        end
      end
    end
    return o;
  endfunction

  // Index of the lowest asserted bit; only meaningful when low != 0.
  function automatic logic [1:0] lowest_col(input logic [COLS-1:0] low);
    logic [1:0] c;
    if (low[0])      c = 2'd0;
    else if (low[1]) c = 2'd1;
    else if (low[2]) c = 2'd2;
    else             c = 2'd3;
    return c;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debouncer operating on whole-scan results.
// Ports: clk, rst_n, scan_end (one-cycle strobe, scan_res valid),
//        scan_res (result of the scan just finished),
//        committed (debounced value), swap (high for the one cycle after a
//        key-to-key commit so the output stage can insert a NONE cycle).
// DEBOUNCE_SCANS must lie in 1..7; the count saturates at 7.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      scan_end,
  input  scan_res_t scan_res,
  output scan_res_t committed,
  output logic      swap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_REQ = CNT_W'(DEBOUNCE_SCANS);

  scan_res_t        cand_q, cand_d;
  scan_res_t        comm_q, comm_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             swap_q, swap_d;

  // Candidate tracking and commit decision, evaluated once per scan.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    comm_d = comm_q;
    swap_d = 1'b0;
    if (scan_end) begin
      if (scan_res == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = scan_res;
        cnt_d  = CNT_W'(1);
      end
      if ((cnt_d >= CNT_REQ) && (cand_d != comm_q)) begin
        comm_d = cand_d;
        // Key replaced by key without a release in between.
        swap_d = (comm_q.kind == RES_KEY) && (cand_d.kind == RES_KEY);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= SCAN_NONE;
      cnt_q  <= '0;
      comm_q <= SCAN_NONE;
      swap_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      comm_q <= comm_d;
      swap_q <= swap_d;
    end
  end

  assign committed = comm_q;
  assign swap      = swap_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner, debouncer and decoder for the coin
// charger control FSM.
// Ports: CLK (381 Hz), rst_n (async, active low), col_n (column sense,
//        pulled up), row_n (one-hot active-low row drive), data (digit or
//        4'b1111), idle, start, ok, reset (levels while key committed).
// Optional build macro KEYPAD_MULTIKEY_ERR_EN: a scan seeing more than one
// key yields ERROR. Without it the lowest key code in the scan wins.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic [CODE_W-1:0] data,
  output logic              idle,
  output logic              start,
  output logic              ok,
  output logic              reset
);

  localparam logic [1:0]      SLOT_LAST = 2'(SLOT_CYCLES - 1);
  localparam logic [1:0]      ROW_LAST  = 2'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_N_RST = 4'b1110;

  logic [1:0]        slot_q,  slot_d;
  logic [1:0]        row_q,   row_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [COLS-1:0]   sync1_q, sync2_q;
  logic              found_q, found_d;
  logic [CODE_W-1:0] code_q,  code_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic              multi_q, multi_d;
  logic              multi_acc_c;
`endif
  key_out_t          out_q,   out_d;

  logic [COLS-1:0]   low_c;
  logic              sample_c;
  logic              scan_end_c;
  logic              found_acc_c;
  logic [CODE_W-1:0] code_acc_c;
  scan_res_t         scan_res_c;
  scan_res_t         committed;
  logic              swap;

  // Row sequencer: 3-cycle slots, rows 0..3, drive updated with the counters.
  always_comb begin
    slot_d = slot_q + 2'd1;
    row_d  = row_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = 2'd0;
      row_d  = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;
    end
    row_n_d = ~(ROWS'(1) << row_d);
  end

  // Sync output at slot cycle 2 reflects col_n from slot cycle 0.
  assign low_c      = ~sync2_q;
  assign sample_c   = (slot_q == SLOT_LAST);
  assign scan_end_c = sample_c && (row_q == ROW_LAST);

  // Fold this row's sample into the running scan; first hit is lowest code.
  always_comb begin
    found_acc_c = found_q;
    code_acc_c  = code_q;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    multi_acc_c = multi_q;
`endif
    if (sample_c && (|low_c)) begin
      if (!found_q) begin
        found_acc_c = 1'b1;
        code_acc_c  = {row_q, lowest_col(low_c)};
      end
`ifdef KEYPAD_MULTIKEY_ERR_EN
      if (found_q || ((low_c & (low_c - COLS'(1))) != '0)) multi_acc_c = 1'b1;
`endif
    end
  end

  // Result of the scan completing this cycle.
  always_comb begin
    scan_res_c = SCAN_NONE;
    if (found_acc_c) begin
      scan_res_c.kind = RES_KEY;
      scan_res_c.code = code_acc_c;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      if (multi_acc_c) begin
        scan_res_c.kind = RES_ERROR;
        scan_res_c.code = ERROR_NUM;
      end
`endif
    end
  end

  // Accumulator restarts empty at every scan boundary.
  always_comb begin
    found_d = found_acc_c;
    code_d  = code_acc_c;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    multi_d = multi_acc_c;
`endif
    if (scan_end_c) begin
      found_d = 1'b0;
      code_d  = '0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      multi_d = 1'b0;
`endif
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (CLK),
    .rst_n     (rst_n),
    .scan_end  (scan_end_c),
    .scan_res  (scan_res_c),
    .committed (committed),
    .swap      (swap)
  );

  // A key-to-key commit shows one cycle of the idle pattern first.
  always_comb begin
    out_d = decode_result(committed);
    if (swap) out_d = OUT_IDLE;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      row_q   <= '0;
      row_n_q <= ROW_N_RST;
      sync1_q <= '1;
      sync2_q <= '1;
      found_q <= 1'b0;
      code_q  <= '0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      multi_q <= 1'b0;
`endif
      out_q   <= OUT_IDLE;
    end else begin
      slot_q  <= slot_d;
      row_q   <= row_d;
      row_n_q <= row_n_d;
      sync1_q <= col_n;
      sync2_q <= sync1_q;
      found_q <= found_d;
      code_q  <= code_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      multi_q <= multi_d;
`endif
      out_q   <= out_d;
    end
  end

  assign row_n = row_n_q;
  assign data  = out_q.data;
  assign idle  = out_q.idle;
  assign start = out_q.start;
  assign ok    = out_q.ok;
  assign reset = out_q.reset;

endmodule
